// File: rtl/riscv_irq_ctrl.sv
// rtl/riscv_irq_ctrl.sv - edge-captured, fixed-priority interrupt controller for the RV32 core
module riscv_irq_ctrl #(
    parameter int NUM_IRQ = 16
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic [NUM_IRQ-1:0] irq_req_i,
    input  logic [NUM_IRQ-1:0] irq_en_i,
    input  logic               glob_en_i,
    input  logic               core_stall_i,
    input  logic               ic_int_rst_i,
    output logic               ic_int_o,
    output logic [NUM_IRQ-1:0] irq_ack_o,
    output logic [31:0]        mcause_o,
    output logic               busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTRY   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] req_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] elig;
    logic               arm_q;
    logic               cause_vld_q;
    logic               take;
    logic [3:0]         id_q;
    logic [3:0]         sel_id;

    // arm_q suppresses edge detection on the first edge after reset, so a
    // line that is already high when reset releases is not an event.
    assign rise = irq_req_i & ~req_q & {NUM_IRQ{arm_q}};
    assign elig = pend_q & irq_en_i;

    always_comb begin
        sel_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                sel_id = 4'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|elig) && glob_en_i && !core_stall_i) begin
                    take    = 1'b1;
                    state_d = ENTRY;
                end
            end
            ENTRY:   state_d = SERVICE;
            SERVICE: begin
                if (ic_int_rst_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            req_q       <= '0;
            pend_q      <= '0;
            arm_q       <= 1'b0;
            id_q        <= '0;
            cause_vld_q <= 1'b0;
            ic_int_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= irq_req_i;
            arm_q    <= 1'b1;
            pend_q   <= (pend_q & ~irq_ack_o) | rise;
            ic_int_o <= take;
            busy_o   <= (state_d != IDLE);
            if (take) begin
                id_q        <= sel_id;
                cause_vld_q <= 1'b1;
            end
        end
    end

    // Both outputs decode flops only: ack follows the entry pulse, and the
    // cause is 0x8000_0010 + id, which is an OR because id < 16.
    assign irq_ack_o = ic_int_o ? (NUM_IRQ'(1) << id_q) : '0;
    assign mcause_o  = {cause_vld_q, 26'd0, cause_vld_q, id_q};

endmodule

// File: tb/tb_riscv_irq_ctrl.sv
// tb/tb_riscv_irq_ctrl.sv - self-checking bench for riscv_irq_ctrl
module tb_riscv_irq_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [15:0] irq_req_i;
    logic [15:0] irq_en_i;
    logic        glob_en_i;
    logic        core_stall_i;
    logic        ic_int_rst_i;
    logic        ic_int_o;
    logic [15:0] irq_ack_o;
    logic [31:0] mcause_o;
    logic        busy_o;

    int n_asserts = 0;
    int n_fails   = 0;

    // Reference model state
    logic [15:0] m_prev, m_pend;
    bit          m_armed, m_busy, m_int;
    int          m_id;
    logic [31:0] m_cause;

    riscv_irq_ctrl #(.NUM_IRQ(16)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .irq_req_i   (irq_req_i),
        .irq_en_i    (irq_en_i),
        .glob_en_i   (glob_en_i),
        .core_stall_i(core_stall_i),
        .ic_int_rst_i(ic_int_rst_i),
        .ic_int_o    (ic_int_o),
        .irq_ack_o   (irq_ack_o),
        .mcause_o    (mcause_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_armed = 0;
        m_busy  = 0;
        m_int   = 0;
        m_id    = 0;
        m_cause = '0;
    endtask

    // One clock edge of the rules: events set pending, the acknowledged line
    // clears, lowest eligible index wins, one pulse, wait for MRET.
    task automatic model_step();
        logic [15:0] elig, rise, clear, low;
        bit          take;
        elig  = m_pend & irq_en_i;
        rise  = m_armed ? (irq_req_i & ~m_prev) : 16'd0;
        take  = !m_busy && (elig != 0) && glob_en_i && !core_stall_i;
        low   = elig & (~elig + 16'd1);
        clear = m_int ? (16'd1 << m_id) : 16'd0;
        m_pend = (m_pend & ~clear) | rise;
        if (take) m_busy = 1;
        else if (m_busy && !m_int && ic_int_rst_i) m_busy = 0;
        m_int = take;
        if (take) begin
            m_id    = $clog2(low);
            m_cause = 32'h8000_0010 + m_id;
        end
        m_prev  = irq_req_i;
        m_armed = 1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".int"},    {31'd0, ic_int_o}, {31'd0, m_int});
        chk({tag, ".ack"},    {16'd0, irq_ack_o}, m_int ? (32'd1 << m_id) : 32'd0);
        chk({tag, ".mcause"}, mcause_o, m_cause);
        chk({tag, ".busy"},   {31'd0, busy_o}, {31'd0, m_busy});
    endtask

    task automatic cyc(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        chk_model(tag);
    endtask

    task automatic mret(input string tag);
        ic_int_rst_i = 1;
        cyc(tag);
        ic_int_rst_i = 0;
    endtask

    initial begin
        rstn_i       = 0;
        irq_req_i    = '0;
        irq_en_i     = '0;
        glob_en_i    = 0;
        core_stall_i = 0;
        ic_int_rst_i = 0;
        model_reset();
        #1;
        chk("reset.int",    {31'd0, ic_int_o}, 32'd0);
        chk("reset.ack",    {16'd0, irq_ack_o}, 32'd0);
        chk("reset.mcause", mcause_o, 32'd0);
        chk("reset.busy",   {31'd0, busy_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rstn_i = 1;
        cyc("post_reset");

        // Single request on line 2
        irq_en_i  = 16'h0004;
        glob_en_i = 1;
        irq_req_i = 16'h0004;
        cyc("t1.pend");
        chk("t1.no_pulse_yet", {31'd0, ic_int_o}, 32'd0);
        cyc("t1.entry");
        chk("t1.pulse", {31'd0, ic_int_o}, 32'd1);
        chk("t1.ack", {16'd0, irq_ack_o}, 32'h0004);
        chk("t1.mcause", mcause_o, 32'h8000_0012);
        chk("t1.busy", {31'd0, busy_o}, 32'd1);
        irq_req_i = '0;
        cyc("t1.service");
        chk("t1.pulse_width", {31'd0, ic_int_o}, 32'd0);
        mret("t1.mret");
        chk("t1.busy_fall", {31'd0, busy_o}, 32'd0);
        chk("t1.mcause_hold", mcause_o, 32'h8000_0012);

        // Priority: lines 5 and 3 together
        irq_en_i  = 16'hffff;
        irq_req_i = 16'h0028;
        cyc("t2.pend");
        cyc("t2.entry1");
        chk("t2.first", mcause_o, 32'h8000_0013);
        irq_req_i = '0;
        cyc("t2.service1");
        mret("t2.mret1");
        cyc("t2.entry2");
        chk("t2.second_pulse", {31'd0, ic_int_o}, 32'd1);
        chk("t2.second", mcause_o, 32'h8000_0015);
        cyc("t2.service2");
        mret("t2.mret2");

        // Masking on line 1, then global disable
        irq_en_i  = 16'hfffd;
        irq_req_i = 16'h0002;
        for (int i = 0; i < 10; i++) begin
            cyc("t3.masked");
            chk("t3.masked_no_int", {31'd0, ic_int_o}, 32'd0);
        end
        irq_en_i = 16'hffff;
        cyc("t3.unmask");
        chk("t3.unmask_cause", mcause_o, 32'h8000_0011);
        cyc("t3.service");
        mret("t3.mret");
        glob_en_i = 0;
        irq_req_i = 16'h0000;
        cyc("t3.drop");
        irq_req_i = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            cyc("t3.glob_off");
            chk("t3.glob_off_no_int", {31'd0, ic_int_o}, 32'd0);
        end
        glob_en_i = 1;
        irq_req_i = '0;
        cyc("t3.glob_on");
        cyc("t3.service2");
        mret("t3.mret2");

        // Stall on line 0
        core_stall_i = 1;
        irq_req_i    = 16'h0001;
        for (int i = 0; i < 4; i++) begin
            cyc("t4.stall");
            chk("t4.stall_no_int", {31'd0, ic_int_o}, 32'd0);
        end
        core_stall_i = 0;
        irq_req_i    = '0;
        cyc("t4.release");
        chk("t4.pulse", {31'd0, ic_int_o}, 32'd1);
        chk("t4.cause", mcause_o, 32'h8000_0010);
        cyc("t4.service");
        mret("t4.mret");

        // No nesting: line 0 arrives while line 4 is in service
        irq_req_i = 16'h0010;
        cyc("t5.pend4");
        cyc("t5.entry4");
        cyc("t5.service4");
        irq_req_i = 16'h0011;
        for (int i = 0; i < 3; i++) begin
            cyc("t5.nonest");
            chk("t5.nonest_no_int", {31'd0, ic_int_o}, 32'd0);
        end
        mret("t5.mret4");
        cyc("t5.entry0");
        chk("t5.cause0", mcause_o, 32'h8000_0010);
        irq_req_i = '0;
        cyc("t5.service0");
        mret("t5.mret0");

        // New edge on line 4 during its own entry cycle
        irq_req_i = 16'h0010;
        cyc("t5b.pend");
        irq_req_i = 16'h0000;
        cyc("t5b.entry");
        irq_req_i = 16'h0010;
        cyc("t5b.reedge");
        irq_req_i = '0;
        mret("t5b.mret");
        cyc("t5b.reentry");
        chk("t5b.reentry_pulse", {31'd0, ic_int_o}, 32'd1);
        chk("t5b.reentry_cause", mcause_o, 32'h8000_0014);
        cyc("t5b.service");
        mret("t5b.mret2");

        // Reset during service with line 7 pending
        irq_req_i = 16'h0040;
        cyc("t6.pend6");
        cyc("t6.entry6");
        irq_req_i = 16'h00c0;
        cyc("t6.pend7");
        chk("t6.in_service", {31'd0, busy_o}, 32'd1);
        #2;
        rstn_i = 0;
        model_reset();
        #1;
        chk("t6.rst_busy",   {31'd0, busy_o}, 32'd0);
        chk("t6.rst_mcause", mcause_o, 32'd0);
        chk("t6.rst_int",    {31'd0, ic_int_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rstn_i = 1;
        for (int i = 0; i < 5; i++) begin
            cyc("t6.held_high");
            chk("t6.no_entry", {31'd0, busy_o}, 32'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            irq_req_i    = irq_req_i ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            irq_en_i     = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hffff;
            glob_en_i    = ($urandom_range(0, 9) != 0);
            core_stall_i = ($urandom_range(0, 3) == 0);
            ic_int_rst_i = ($urandom_range(0, 4) == 0);
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
